stack_reader: RTL
=================

STACK_READER -- requirements
Module: stack_reader

Interface
REQ-001 Parameter SETTLE_CYC, default 2: idle cycles after each pop before the stack status is trusted.
REQ-002 Parameter DEPTH, default 256: stack capacity; CW = $clog2(DEPTH)+1 = 9.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  request to drain the stack; sampled only in IDLE.
REQ-006 stk_empty  in  1  registered stack-empty flag.
REQ-007 stk_top  in  2  registered top-of-stack symbol.
REQ-008 stk_pop  out  1  one-cycle pop strobe to the stack.
REQ-009 out_data  out  2  drained symbol, LIFO order.
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_ready  in  1  consumer accepts out_data.
REQ-012 out_last  out  1  with out_valid: final symbol of this drain.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a drain completes.
REQ-015 count  out  CW  symbols transferred in the current or last drain.

Function
REQ-016 FSM states: IDLE, SETTLE, CHECK, SEND, DONE.
REQ-017 IDLE: start=1 -> SETTLE, count cleared to 0; start while busy is ignored.
REQ-018 SETTLE: wait counter runs SETTLE_CYC cycles, then -> CHECK.
REQ-019 CHECK, stk_empty=1 -> DONE; no pop issued.
REQ-020 CHECK, stk_empty=0 -> latch stk_top into out_data, assert stk_pop for exactly this cycle, -> SEND.
REQ-021 SEND: out_valid=1; out_data is stable until the handshake.
REQ-022 Handshake completes on the first edge with out_valid=1 and out_ready=1: count+1, -> SETTLE.
REQ-023 out_last=1 in SEND only when count+1 = DEPTH (the pop emptied a full stack); otherwise the end of a drain is signalled by done.
REQ-024 DONE: done=1 for one cycle, -> IDLE; count holds until the next start.
REQ-025 stk_pop is never asserted outside CHECK, and at most once per symbol.
REQ-026 A drain of an empty stack: start -> done after SETTLE_CYC+2 cycles, count=0, no out_valid.
REQ-027 Latency per symbol with out_ready held at 1: SETTLE_CYC+2 cycles.
REQ-028 count saturates at DEPTH and does not wrap.

Reset
REQ-029 rst low forces IDLE immediately: stk_pop=0, out_valid=0, out_last=0, busy=0, done=0, out_data=2'b00, count=0, wait counter=0.
REQ-030 rst asserted mid-drain abandons the drain; a pending symbol is dropped without a handshake.

Configuration
REQ-031 Macro STACK_READER_MAXLEN_EN: when defined, add input max_len [CW-1:0], sampled on start.
REQ-032 With the macro: CHECK -> DONE also when count = max_len, and out_last=1 on the symbol where count+1 = max_len; max_len=0 behaves like an empty stack.
REQ-033 Without the macro: no max_len port; the drain always runs until stk_empty.

Structure
REQ-034 Shared package stack_pkg holds the FSM state enum, the symbol type (2-bit), and DEPTH/CW constants.
REQ-035 Sub-module stack_reader_settle: a down-counter producing the SETTLE expiry pulse.

Verification
REQ-036 Empty stack, start=1 -> no stk_pop, done after 4 cycles (SETTLE_CYC=2), count=0.
REQ-037 Push 2'b01, 2'b10, 2'b11, out_ready=1 -> out_data 11, 10, 01; exactly 3 stk_pop pulses; done; count=3.
REQ-038 Same 3-symbol load, out_ready low 5 cycles on the 2nd symbol -> out_data=10 held stable, no extra pop, count=3.
REQ-039 256 pushes -> 256 symbols, out_last only on the 256th, count=256 with no wrap.
REQ-040 rst low mid-SEND -> all outputs take reset values asynchronously; start after release begins a fresh drain with count=0.
REQ-041 STACK_READER_MAXLEN_EN with max_len=2 on a 3-deep stack -> 2 symbols, out_last on the 2nd, one symbol left in the stack, done.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and default sizing for the stack reader.
package stack_pkg;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef logic [1:0] symbol_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/stack_reader_if.sv
// Stack-side and output-stream signals of the stack reader.
interface stack_reader_if;
  import stack_pkg::*;

  logic    stk_empty;
  symbol_t stk_top;
  logic    stk_pop;
  symbol_t out_data;
  logic    out_valid;
  logic    out_ready;
  logic    out_last;

  modport master (
    input  stk_empty, stk_top, out_ready,
    output stk_pop, out_data, out_valid, out_last
  );

  modport slave (
    output stk_empty, stk_top, out_ready,
    input  stk_pop, out_data, out_valid, out_last
  );

endinterface

// File: rtl/stack_reader_settle.sv
// Settle-time down-counter: expire pulses on the last cycle of a SETTLE_CYC-long run (SETTLE_CYC >= 1).
module stack_reader_settle #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int unsigned   WW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [WW-1:0] PRELOAD = WW'(SETTLE_CYC - 1);

  logic [WW-1:0] cnt;

  // Preloaded whenever not running, so it is armed on the first SETTLE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cnt <= '0;
    else if (!run)       cnt <= PRELOAD;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/stack_reader.sv
// Drains a registered stack symbol by symbol onto a valid/ready stream.
// Optional STACK_READER_MAXLEN_EN adds a max_len port limiting symbols per drain.
module stack_reader
  import stack_pkg::*;
#(
  parameter  int unsigned SETTLE_CYC = 2,
  parameter  int unsigned DEPTH      = stack_pkg::DEPTH,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  stack_reader_if.master  bus,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   count
`ifdef STACK_READER_MAXLEN_EN
  ,
  input  logic [CW-1:0]   max_len
`endif
);

  state_t    state, state_nx;
  symbol_t   data_q;
  logic      last_q;
  logic      settle_exp;
  logic      stop;
  logic      last_nx;
  logic      handshake;
  logic [CW:0] next_cnt;

  stack_reader_settle #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .run    (state == SETTLE),
    .expire (settle_exp)
  );

  assign next_cnt  = {1'b0, count} + 1'b1;
  assign handshake = (state == SEND) && bus.out_ready;

`ifdef STACK_READER_MAXLEN_EN
  logic [CW-1:0] len_q;
  assign stop    = bus.stk_empty || (count == len_q);
  assign last_nx = (next_cnt == (CW+1)'(DEPTH)) || (next_cnt == {1'b0, len_q});
`else
  assign stop    = bus.stk_empty;
  assign last_nx = (next_cnt == (CW+1)'(DEPTH));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETTLE;
      SETTLE:  if (settle_exp) state_nx = CHECK;
      CHECK:   state_nx = stop ? DONE : SEND;
      SEND:    if (bus.out_ready) state_nx = SETTLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.stk_pop   = (state == CHECK) && !stop;
    bus.out_valid = (state == SEND);
    bus.out_last  = (state == SEND) && last_q;
    bus.out_data  = data_q;
    busy          = (state != IDLE);
    done          = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      last_q <= 1'b0;
      count  <= '0;
`ifdef STACK_READER_MAXLEN_EN
      len_q  <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        count <= '0;
`ifdef STACK_READER_MAXLEN_EN
        len_q <= max_len;
`endif
      end
      if (state == CHECK && !stop) begin
        data_q <= bus.stk_top;
        last_q <= last_nx;
      end
      if (handshake && count != CW'(DEPTH)) count <= count + 1'b1;
    end
  end

endmodule
